// File: rtl/cp0_pkg.sv
// Purpose: shared CP0 register numbers, bit positions and the interrupt priority encoder.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: none.
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    // Bit positions inside Status / Cause
    localparam int BIT_IE       = 0;
    localparam int BIT_EXL      = 1;
    localparam int BIT_IM_LO    = 8;
    localparam int BIT_IP_TIMER = 15;
    localparam int BIT_IP_HW_LO = 10;
    localparam int BIT_IP_SW_LO = 8;

    // Highest set bit wins; returns 0 for an all-zero vector.
    function automatic logic [2:0] prio_enc(input logic [7:0] v);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) id = 3'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Purpose: prescaler + Count/Compare timer with a sticky TI pending flag.
// Latency: Count/Compare/TI update on the clock edge; writes visible next cycle.
// Backpressure: none; register writes are always accepted.
//
// Ports: clock/reset (async active-low), count_we/compare_we write strobes,
// wr_data write value, count/compare register values, ti timer pending.
module cp0_timer #(
    parameter int PRESCALE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] prescaler;
    logic            tick;
    logic [31:0]     count_inc;

    assign tick      = (prescaler == PS_LAST);
    assign count_inc = count + 32'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            count     <= '0;
        end else if (count_we) begin
            // A software write overrides the increment and restarts the prescaler.
            prescaler <= '0;
            count     <= wr_data;
        end else if (tick) begin
            prescaler <= '0;
            count     <= count_inc;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            compare <= '0;
            ti      <= 1'b0;
        end else if (compare_we) begin
            // Writing Compare is the only way to acknowledge the timer.
            compare <= wr_data;
            ti      <= 1'b0;
        end else if (tick && !count_we && (count_inc == compare)) begin
            // Match against the post-increment value so TI rises with Count.
            ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_irq.sv
// Purpose: CP0 with Status/Cause/EPC, vectored maskable interrupts and Count/Compare timer.
// Latency: irq registered once (1 cycle to TakenInterrupt); reads combinational.
// Backpressure: none; MTC0/ERET are accepted every cycle.
//
// Ports: clock/reset (async active-low); wr_data/regnum/MTC0 register write;
// regnum/rd_data register read; next_pc saved to EPC when an interrupt is taken;
// ERET clears EXL; irq level external lines; TakenInterrupt/int_id winning line.
module cp0_irq
    import cp0_pkg::*;
#(
    parameter int NUM_IRQ  = 5,
    parameter int PC_W     = 30,
    parameter int PRESCALE = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        wr_data,
    input  logic [4:0]         regnum,
    input  logic [PC_W-1:0]    next_pc,
    input  logic               MTC0,
    input  logic               ERET,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [31:0]        rd_data,
    output logic [PC_W-1:0]    EPC,
    output logic               TakenInterrupt,
    output logic [2:0]         int_id
);

    logic [7:0]         im;
    logic               ie;
    logic               exl;
    logic [1:0]         ip_sw;
    logic [NUM_IRQ-1:0] irq_q;
    logic [31:0]        count;
    logic [31:0]        compare;
    logic               ti;
    logic [15:0]        ip_full;
    logic [7:0]         pending;

    cp0_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .count_we   (MTC0 && (regnum == REG_COUNT)),
        .compare_we (MTC0 && (regnum == REG_COMPARE)),
        .wr_data    (wr_data),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // Cause.IP in its architectural position; bits 7:0 are always zero.
    always_comb begin
        ip_full = '0;
        ip_full[BIT_IP_TIMER] = ti;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ip_full[BIT_IP_HW_LO + i] = irq_q[i];
        end
        ip_full[BIT_IP_SW_LO +: 2] = ip_sw;
    end

    assign pending        = ip_full[15:8] & im;
    assign TakenInterrupt = ie & ~exl & (|pending);
    assign int_id         = prio_enc(pending);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            im    <= '0;
            ie    <= 1'b0;
            exl   <= 1'b0;
            ip_sw <= '0;
            irq_q <= '0;
            EPC   <= '0;
        end else begin
            irq_q <= irq;
            if (MTC0 && (regnum == REG_STATUS)) begin
                im <= wr_data[BIT_IM_LO +: 8];
                ie <= wr_data[BIT_IE];
            end
            if (MTC0 && (regnum == REG_CAUSE)) begin
                ip_sw <= wr_data[BIT_IP_SW_LO +: 2];
            end
            // Taking an interrupt requires EXL=0, so it never races an effective ERET.
            if (TakenInterrupt) begin
                exl <= 1'b1;
            end else if (ERET) begin
                exl <= 1'b0;
            end
            // The hardware-saved return address beats a software EPC write.
            if (TakenInterrupt) begin
                EPC <= next_pc;
            end else if (MTC0 && (regnum == REG_EPC)) begin
                EPC <= wr_data[PC_W+1:2];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (regnum)
            REG_COUNT:   rd_data = count;
            REG_COMPARE: rd_data = compare;
            REG_STATUS:  rd_data = {16'b0, im, 6'b0, exl, ie};
            REG_CAUSE:   rd_data = {ip_full[15:8], 8'b0} | 32'h0;
            REG_EPC:     rd_data[PC_W+1:0] = {EPC, 2'b00};
            default:     rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_irq.sv
module tb_cp0_irq;

    logic        clock;
    logic        reset;
    logic [31:0] wr_data;
    logic [4:0]  regnum;
    logic [29:0] next_pc;
    logic        MTC0;
    logic        ERET;
    logic [4:0]  irq;
    logic [31:0] rd_data;
    logic [29:0] EPC;
    logic        TakenInterrupt;
    logic [2:0]  int_id;

    int n_checks = 0;
    int n_fail   = 0;

    cp0_irq #(.NUM_IRQ(5), .PC_W(30), .PRESCALE(1)) dut (
        .clock          (clock),
        .reset          (reset),
        .wr_data        (wr_data),
        .regnum         (regnum),
        .next_pc        (next_pc),
        .MTC0           (MTC0),
        .ERET           (ERET),
        .irq            (irq),
        .rd_data        (rd_data),
        .EPC            (EPC),
        .TakenInterrupt (TakenInterrupt),
        .int_id         (int_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        MTC0 = 1'b1; regnum = r; wr_data = d;
        tick();
        MTC0 = 1'b0; wr_data = '0;
    endtask

    task automatic do_reset();
        MTC0 = 0; ERET = 0; irq = '0; wr_data = '0; next_pc = '0; regnum = '0;
        reset = 1'b0;
        #3;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] regs [5];
        regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
        MTC0 = 0; ERET = 0; irq = '0; wr_data = '0; next_pc = '0; regnum = '0;
        reset = 1'b0;
        #12;
        for (int i = 0; i < 5; i++) begin
            regnum = regs[i]; #1;
            n_checks++;
            if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h exp %h", regs[i], rd_data, 32'h0); end
        end
        n_checks++;
        if (TakenInterrupt !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b exp 0", TakenInterrupt); end
        n_checks++;
        if (int_id !== 3'd0) begin n_fail++; $display("FAIL reset_int_id: got %0d exp 0", int_id); end
        tick();
        reset = 1'b1; regnum = 5'd9;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (rd_data !== 32'd3) begin n_fail++; $display("FAIL count_run: got %0d exp 3", rd_data); end
    endtask

    task automatic test_irq();
        do_reset();
        mtc0(5'd12, 32'h0000_0401);
        next_pc = 30'h0000_1234;
        irq = 5'b00001;
        #1;
        n_checks++;
        if (TakenInterrupt !== 1'b0) begin n_fail++; $display("FAIL irq_latency0: got %b exp 0", TakenInterrupt); end
        tick();
        n_checks++;
        if (TakenInterrupt !== 1'b1) begin n_fail++; $display("FAIL irq_taken: got %b exp 1", TakenInterrupt); end
        n_checks++;
        if (int_id !== 3'd2) begin n_fail++; $display("FAIL irq_int_id: got %0d exp 2", int_id); end
        tick();
        regnum = 5'd12; #1;
        n_checks++;
        if (rd_data !== 32'h0000_0403) begin n_fail++; $display("FAIL irq_status_exl: got %h exp %h", rd_data, 32'h403); end
        regnum = 5'd14; #1;
        n_checks++;
        if (rd_data !== 32'h0000_48D0) begin n_fail++; $display("FAIL irq_epc: got %h exp %h", rd_data, 32'h48D0); end
        regnum = 5'd13; #1;
        n_checks++;
        if (rd_data !== 32'h0000_0400) begin n_fail++; $display("FAIL irq_cause: got %h exp %h", rd_data, 32'h400); end
    endtask

    // Continues from test_irq: EXL=1, irq[0] still high.
    task automatic test_eret();
        tick(); tick();
        n_checks++;
        if (TakenInterrupt !== 1'b0) begin n_fail++; $display("FAIL exl_blocks: got %b exp 0", TakenInterrupt); end
        ERET = 1'b1; #1;
        n_checks++;
        if (TakenInterrupt !== 1'b0) begin n_fail++; $display("FAIL eret_same_cycle: got %b exp 0", TakenInterrupt); end
        tick();
        ERET = 1'b0; #1;
        n_checks++;
        if (TakenInterrupt !== 1'b1) begin n_fail++; $display("FAIL eret_retake: got %b exp 1", TakenInterrupt); end
        irq = '0;
    endtask

    task automatic test_priority();
        do_reset();
        mtc0(5'd12, 32'h0000_8C01);
        mtc0(5'd9, 32'h0);
        regnum = 5'd9; #1;
        n_checks++;
        if (rd_data !== 32'h0) begin n_fail++; $display("FAIL count_write_wins: got %0d exp 0", rd_data); end
        mtc0(5'd11, 32'd3);
        irq = 5'b00011;
        tick();
        n_checks++;
        if (int_id !== 3'd3) begin n_fail++; $display("FAIL prio_hw: got %0d exp 3", int_id); end
        tick();
        n_checks++;
        if (int_id !== 3'd7) begin n_fail++; $display("FAIL prio_timer: got %0d exp 7", int_id); end
        regnum = 5'd13; #1;
        n_checks++;
        if (rd_data !== 32'h0000_8C00) begin n_fail++; $display("FAIL prio_cause: got %h exp %h", rd_data, 32'h8C00); end
        n_checks++;
        if (TakenInterrupt !== 1'b0) begin n_fail++; $display("FAIL prio_exl_blocks: got %b exp 0", TakenInterrupt); end
        mtc0(5'd11, 32'h100);
        n_checks++;
        if (int_id !== 3'd3) begin n_fail++; $display("FAIL prio_ti_cleared: got %0d exp 3", int_id); end
        irq = '0;
    endtask

    task automatic test_timer();
        do_reset();
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd5);
        regnum = 5'd13;
        tick(); tick(); tick();
        n_checks++;
        if (rd_data !== 32'h0) begin n_fail++; $display("FAIL timer_before: got %h exp 0", rd_data); end
        tick();
        n_checks++;
        if (rd_data !== 32'h0000_8000) begin n_fail++; $display("FAIL timer_ti: got %h exp %h", rd_data, 32'h8000); end
        n_checks++;
        if (TakenInterrupt !== 1'b1) begin n_fail++; $display("FAIL timer_taken: got %b exp 1", TakenInterrupt); end
        regnum = 5'd9; #1;
        n_checks++;
        if (rd_data !== 32'd5) begin n_fail++; $display("FAIL timer_count5: got %0d exp 5", rd_data); end
        mtc0(5'd9, 32'hFFFF_FFFF);
        n_checks++;
        if (rd_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_pre: got %h exp ffffffff", rd_data); end
        tick();
        n_checks++;
        if (rd_data !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got %h exp 0", rd_data); end
        regnum = 5'd13; #1;
        n_checks++;
        if (rd_data !== 32'h0000_8000) begin n_fail++; $display("FAIL ti_sticky: got %h exp %h", rd_data, 32'h8000); end
        // Compare write on the edge where Count reaches Compare: write wins.
        do_reset();
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd2);
        mtc0(5'd11, 32'd2);
        regnum = 5'd13; #1;
        n_checks++;
        if (rd_data !== 32'h0) begin n_fail++; $display("FAIL compare_write_wins: got %h exp 0", rd_data); end
    endtask

    task automatic test_swint();
        do_reset();
        mtc0(5'd13, 32'hFFFF_FFFF);
        regnum = 5'd13; #1;
        n_checks++;
        if (rd_data !== 32'h0000_0300) begin n_fail++; $display("FAIL sw_cause: got %h exp %h", rd_data, 32'h300); end
        mtc0(5'd12, 32'h0000_0301);
        n_checks++;
        if (int_id !== 3'd1) begin n_fail++; $display("FAIL sw_int_id: got %0d exp 1", int_id); end
        n_checks++;
        if (TakenInterrupt !== 1'b1) begin n_fail++; $display("FAIL sw_taken: got %b exp 1", TakenInterrupt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mtc0(5'd12, 32'h0000_0401);
        irq = 5'b00001;
        next_pc = 30'h0000_0ABC;
        tick();
        // Taken this cycle, together with an EPC write.
        MTC0 = 1'b1; regnum = 5'd14; wr_data = 32'hFFFF_FFFC; #1;
        n_checks++;
        if (TakenInterrupt !== 1'b1) begin n_fail++; $display("FAIL b2b_taken: got %b exp 1", TakenInterrupt); end
        tick();
        MTC0 = 1'b0; wr_data = '0; #1;
        n_checks++;
        if (rd_data !== 32'h0000_2AF0) begin n_fail++; $display("FAIL b2b_epc: got %h exp %h", rd_data, 32'h2AF0); end
        // Taken together with a Status write.
        do_reset();
        mtc0(5'd12, 32'h0000_0401);
        irq = 5'b00001;
        tick();
        mtc0(5'd12, 32'h0);
        regnum = 5'd12; #1;
        n_checks++;
        if (rd_data !== 32'h0000_0002) begin n_fail++; $display("FAIL b2b_status: got %h exp %h", rd_data, 32'h2); end
        // Asynchronous reset mid-cycle while EXL=1.
        #2;
        reset = 1'b0; #1;
        n_checks++;
        if (rd_data !== 32'h0) begin n_fail++; $display("FAIL arst_status: got %h exp 0", rd_data); end
        regnum = 5'd14; #1;
        n_checks++;
        if (rd_data !== 32'h0) begin n_fail++; $display("FAIL arst_epc: got %h exp 0", rd_data); end
        regnum = 5'd9; #1;
        n_checks++;
        if (rd_data !== 32'h0) begin n_fail++; $display("FAIL arst_count: got %h exp 0", rd_data); end
        irq = '0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_irq();
        test_eret();
        test_priority();
        test_timer();
        test_swint();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_irq.md
Name: cp0_irq

Overview:
- Parametrised coprocessor-0 successor for the Lab9-style MIPS core.
- Adds a vectored, maskable interrupt controller with NUM_IRQ external lines, two software interrupt bits, and a built-in Count/Compare timer with prescaler.
- Holds Status, Cause, EPC, Count and Compare; raises TakenInterrupt and reports the winning line.
- Sits beside the register file; the datapath reads it via MFC0, writes it via MTC0, and returns via ERET.

Parameters:
- NUM_IRQ, 5, external interrupt lines (1..5), mapped to Cause/Status bits [10+i].
- PC_W, 30, width of next_pc/EPC (word address).
- PRESCALE, 1, clock cycles per Count increment (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_data  in  32  MTC0 write data.
- regnum  in  5  CP0 register select (read and write).
- next_pc  in  PC_W  PC saved into EPC on interrupt.
- MTC0  in  1  write strobe.
- ERET  in  1  return from exception; clears EXL.
- irq  in  NUM_IRQ  level-sensitive external interrupts, synchronous to clock.
- rd_data  out  32  combinational read of regnum.
- EPC  out  PC_W  saved PC.
- TakenInterrupt  out  1  combinational; an interrupt is taken this cycle.
- int_id  out  3  index of the winning IP bit minus 8 (0..7); 0 when none.

Behaviour:
- Register map:
  - 9 = Count.
  - 11 = Compare.
  - 12 = Status {16'b0, IM[15:8], 6'b0, EXL, IE}.
  - 13 = Cause {16'b0, IP[15:8], 8'b0}.
  - 14 = {EPC, 2'b0}.
  - All other regnum values read 0.
- Reset (reset low, asynchronous): IM=0, IE=0, EXL=0, SW IP[9:8]=0, irq_q=0, Count=0, Compare=0, TI=0, prescaler=0, EPC=0. TakenInterrupt and int_id are therefore 0.
- MTC0 to 12 writes IM and IE only; EXL is hardware-owned.
- MTC0 to 13 writes IP[9:8] only.
- MTC0 to 14 writes EPC <= wr_data[PC_W+1:2].
- IP composition:
  - IP[15] = TI (sticky timer pending).
  - IP[10+i] = irq_q[i], for i < NUM_IRQ.
  - Unused IP bits read 0.
  - IP[9:8] = software bits.
- irq is registered once (irq_q), so the interrupt latency is 1 cycle: TakenInterrupt can first assert in the cycle after irq rises.
- pending = IP & IM.
- TakenInterrupt = IE & ~EXL & |pending.
- int_id = highest set bit of pending, minus 8. Priority is fixed, highest index wins (timer first, SW0 last).
- On a TakenInterrupt cycle, at the clock edge:
  - EXL <= 1.
  - EPC <= next_pc.
- ERET: EXL <= 0. ERET with EXL=0 is a no-op.
- Timer:
  - The prescaler counts 0..PRESCALE-1; Count increments when the prescaler wraps.
  - Count wraps 2^32-1 -> 0.
  - TI sets on any cycle where Count==Compare and Count has just incremented. Comparison uses the post-increment value, so TI sets on the edge where Count becomes equal to Compare.
  - TI clears only on an MTC0 write to 11.
- Simultaneous events:
  - TakenInterrupt and MTC0-to-14 in the same cycle: next_pc wins.
  - TakenInterrupt and MTC0-to-12 in the same cycle: IM/IE take wr_data and EXL still sets.
  - MTC0 to 9 and a Count increment in the same cycle: the write wins and the prescaler resets to 0.
  - MTC0 to 11 and a TI-set condition in the same cycle: the write wins (TI=0).
- EXL=1 blocks new interrupts, so no nesting occurs. Pending lines remain visible in Cause.
- Reset asserted mid-operation: all state returns to reset values immediately.

Decomposition:
- Package cp0_pkg holds:
  - Register numbers: REG_COUNT=9, REG_COMPARE=11, REG_STATUS=12, REG_CAUSE=13, REG_EPC=14.
  - Bit positions: IE=0, EXL=1, IM_LO=8, IP_TIMER=15, IP_HW_LO=10, IP_SW_LO=8.
- One sub-module, cp0_timer: contains prescaler, Count, Compare and TI. Its ports are clock, reset, write enables, wr_data, count, compare and ti.
- The priority encoder, register file and read mux stay in cp0_irq.

Test Plan:
- Reset then read regs 9/11/12/13/14 -> all 0, TakenInterrupt=0, Count begins incrementing (PRESCALE=1): reg 9 reads 3 after 3 cycles.
- MTC0 Status=0x0000_0401, then raise irq[0] -> TakenInterrupt=1 one cycle after irq rises, int_id=2; after the edge EXL=1 (Status reads 0x403) and EPC=next_pc (0x0000_1234 gives reg14=0x0000_48D0).
- With EXL=1 and irq held, TakenInterrupt stays 0. ERET -> EXL=0 and TakenInterrupt reasserts next cycle.
- Status=0x0000_8C01, irq[0]=1, irq[1]=1 and TI pending together -> int_id=7 (timer). MTC0 Compare clears TI -> int_id=3.
- Compare=5, Count=0, Status=0x8001, PRESCALE=1 -> Cause bit15 sets on the edge where Count becomes 5; TakenInterrupt next cycle. Count=0xFFFF_FFFF wraps to 0.
- TakenInterrupt and MTC0 to reg 14 in the same cycle with wr_data=0xFFFF_FFFC -> EPC holds next_pc. Assert reset while EXL=1 -> EXL, EPC and Count read 0 immediately.
